systolic_tile_engine: RTL and testbench
=======================================

Name: systolic_tile_engine

Overview:
Parametrised M x N output-stationary systolic MAC array with its own tile controller.
- Accepts one A column-vector (M lanes) and one B row-vector (N lanes) per handshake beat, for k_len beats.
- Skews the operands internally, accumulates C[i][j] = sum_k A[i][k]*B[k][j], then streams the M*N results out row-major over a valid/ready port.
- Successor to the fixed 4x4 systolic_top: adds runtime K depth, vector inputs, an explicit FSM, and a result drain port.

Parameters:
- M, 4, array rows (A lanes)
- N, 4, array columns (B lanes)
- DATA_W, 8, signed operand width
- ACC_W, 32, signed accumulator width (>= 2*DATA_W)
- KW, 8, width of k_len

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle request to begin a tile; sampled only in IDLE
- k_len  in  KW  number of operand beats for the tile, sampled with start
- in_a  in  M*DATA_W  A lanes; lane i at bits [i*DATA_W +: DATA_W]
- in_b  in  N*DATA_W  B lanes, same packing
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts a beat
- out_data  out  ACC_W  result word
- out_row  out  $clog2(M)  row index of out_data
- out_col  out  $clog2(N)  column index of out_data
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the final result handshake

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all outputs 0; FSM in IDLE; accumulators, skew registers and PE pipelines cleared.
- IDLE: start=1 clears all accumulators, latches k_len, and enters FEED. If k_len=0, it enters DRAIN directly, and all results are 0.
- FEED:
  - in_ready=1.
  - A beat is accepted when in_valid & in_ready; the beat counter increments on each accepted beat.
  - in_valid=0 inserts a bubble, which is injected into the array as an invalid token.
  - After k_len beats are accepted, go to FLUSH; in_ready drops the cycle after the last accepted beat.
- FLUSH: in_ready=0 for exactly M+N-1 cycles, injecting invalid tokens, then go to DRAIN.
- Skew: lane i of A is delayed i cycles and lane j of B is delayed j cycles. A/B values and their valid bits propagate one PE per cycle, rightwards for A and downwards for B.
- PE MAC rule: a PE accumulates only when both incoming valids are 1: acc <= acc + sext(a*b). The product is a full 2*DATA_W signed value, sign-extended; the accumulator wraps modulo 2^ACC_W.
- DRAIN:
  - Results are emitted in order (0,0),(0,1)..(M-1,N-1).
  - out_valid=1 throughout. out_data, out_row and out_col hold stable while out_valid & !out_ready.
  - The index advances only on handshake.
  - On the last handshake: done=1 for one cycle, and the next state is IDLE.
- start outside IDLE is ignored.
- in_valid outside FEED is ignored; no beat is consumed.
- Reset asserted mid-tile: immediate return to IDLE with all state cleared. No done pulse is generated and no partial result is emitted.
- Tile latency with no bubbles and out_ready=1: first out_valid appears k_len+M+N cycles after start.

Optional Feature:
- RELU_EN defined: each drained result is clamped so that a negative accumulator is output as 0. The accumulators themselves are unaffected.
- RELU_EN undefined: the raw signed accumulator value is output.

Decomposition:
- Package systolic_pkg holds:
  - FSM state enum: IDLE, FEED, FLUSH, DRAIN.
  - Default constants for DATA_W and ACC_W.
- Sub-module systolic_pe contains:
  - Registered a/b and valid forwarding.
  - Clear input.
  - Accumulator register acc_reg, so hierarchical probing works in RTL and gate-level simulation.
- The top level generates the M x N PE grid plus the skew register chains.

Test Plan:
1. Defaults; k_len=5; every A and B lane in beat k = 2+k and 3+k respectively -> all 16 results = 110; done pulses once.
2. k_len=4; A = identity, B[k][j] = 4k+j+1 -> result (i,j) = 4i+j+1, emitted row-major with correct out_row and out_col.
3. Scenario 2 with in_valid deasserted every other cycle and out_ready toggled 1,0,0,1 -> identical results; data held stable while stalled; no lost or duplicate words.
4. k_len=1, all lanes a=-128, b=-128 -> all results 16384. Then a=-1, b=1 -> -1 without RELU_EN, 0 with RELU_EN.
5. start pulsed during FEED and during DRAIN; k_len=0 tile -> ignored starts change nothing; the k_len=0 tile drains 16 zeros.
6. rst_n asserted during DRAIN after 5 words; new tile with scenario 1 stimulus -> outputs reset to 0 asynchronously; the next tile yields 110 everywhere.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the systolic tile engine.
//   state_e     - tile controller states (IDLE, FEED, FLUSH, DRAIN)
//   DEF_DATA_W  - default signed operand width
//   DEF_ACC_W   - default signed accumulator width
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one output-stationary MAC cell of the systolic grid.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   clr_i                 - synchronous clear of accumulator and forwarding regs
//   a_i/a_valid_i         - operand arriving from the left neighbour
//   b_i/b_valid_i         - operand arriving from the upper neighbour
//   a_o/a_valid_o         - registered A forwarded to the right
//   b_o/b_valid_o         - registered B forwarded downwards
//   acc_o                 - current accumulator value (acc_reg)
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              b_valid_i,
  output logic [DATA_W-1:0] a_o,
  output logic              a_valid_o,
  output logic [DATA_W-1:0] b_o,
  output logic              b_valid_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    prod_ext_s;
  logic        [ACC_W-1:0]    acc_reg;

  // Full-width signed product, then sign-extended to the accumulator width.
  assign prod_s     = $signed(a_i) * $signed(b_i);
  assign prod_ext_s = ACC_W'(prod_s);
  assign acc_o      = acc_reg;

  // Operand forwarding and MAC; only a pair of valid tokens contributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o       <= {DATA_W{1'b0}};
      a_valid_o <= 1'b0;
      b_o       <= {DATA_W{1'b0}};
      b_valid_o <= 1'b0;
      acc_reg   <= {ACC_W{1'b0}};
    end else if (clr_i) begin
      a_o       <= {DATA_W{1'b0}};
      a_valid_o <= 1'b0;
      b_o       <= {DATA_W{1'b0}};
      b_valid_o <= 1'b0;
      acc_reg   <= {ACC_W{1'b0}};
    end else begin
      a_o       <= a_i;
      a_valid_o <= a_valid_i;
      b_o       <= b_i;
      b_valid_o <= b_valid_i;
      if (a_valid_i && b_valid_i) begin
        acc_reg <= acc_reg + prod_ext_s;
      end
    end
  end

endmodule

// File: rtl/systolic_tile_engine.sv
// systolic_tile_engine: M x N output-stationary systolic MAC array with a
// tile controller. Operand vectors are accepted for k_len beats, skewed into
// the grid, flushed, and the M*N results are drained row-major.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   start, k_len            - tile request and depth (sampled in IDLE)
//   in_a, in_b              - A column-vector / B row-vector, lane-packed
//   in_valid, in_ready      - operand beat handshake
//   out_data/out_row/out_col- result word and its (row, col) position
//   out_valid, out_ready    - result handshake
//   busy, done              - not-idle flag, final-result handshake pulse
// Build option: define RELU_EN to clamp negative drained results to 0.
module systolic_tile_engine
  import systolic_pkg::*;
#(
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int KW     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic [M*DATA_W-1:0]   in_a,
  input  logic [N*DATA_W-1:0]   in_b,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [$clog2(M)-1:0]  out_row,
  output logic [$clog2(N)-1:0]  out_col,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int RW = $clog2(M);
  localparam int CW = $clog2(N);
  localparam int IW = $clog2(M*N);
  localparam int FW = $clog2(M+N) + 1;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   fl_q, fl_d;
  logic [IW-1:0]   idx_q, idx_d, idx_nx_s;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;

  logic            clr_s;
  logic            inj_v_s;

  logic [DATA_W-1:0] a_h_s  [M][N+1];
  logic              av_h_s [M][N+1];
  logic [DATA_W-1:0] b_v_s  [M+1][N];
  logic              bv_v_s [M+1][N];
  logic [ACC_W-1:0]  acc_s  [M*N];

  // Drained-word shaping; the accumulators themselves are never altered.
  function automatic logic [ACC_W-1:0] drain_word(input logic [ACC_W-1:0] acc);
`ifdef RELU_EN
    if (acc[ACC_W-1]) begin
      return {ACC_W{1'b0}};
    end else begin
      return acc;
    end
`else
    return acc;
`endif
  endfunction

  assign clr_s    = (state_q == IDLE) && start;
  // Bubbles enter the array as invalid tokens so skew alignment is preserved.
  assign inj_v_s  = (state_q == FEED) && in_valid;
  assign in_ready = (state_q == FEED);
  assign busy     = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign idx_nx_s  = idx_q + IW'(1);
  assign done      = out_valid_q && out_ready && (idx_q == IW'(M*N-1));

  genvar gi, gj;
  // A skew: lane i passes through i registers before entering column 0.
  for (gi = 0; gi < M; gi++) begin : g_askew
    if (gi == 0) begin : g_direct
      assign a_h_s[0][0]  = in_a[DATA_W-1:0];
      assign av_h_s[0][0] = inj_v_s;
    end else begin : g_chain
      logic [DATA_W-1:0] d_q [gi];
      logic              v_q [gi];
      // Delay line for A lane gi.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr_s) begin
          for (int k = 0; k < gi; k++) begin
            d_q[k] <= {DATA_W{1'b0}};
            v_q[k] <= 1'b0;
          end
        end else begin
          d_q[0] <= in_a[gi*DATA_W +: DATA_W];
          v_q[0] <= inj_v_s;
          for (int k = 1; k < gi; k++) begin
            d_q[k] <= d_q[k-1];
            v_q[k] <= v_q[k-1];
          end
        end
      end
      assign a_h_s[gi][0]  = d_q[gi-1];
      assign av_h_s[gi][0] = v_q[gi-1];
    end
  end

  // B skew: lane j passes through j registers before entering row 0.
  for (gj = 0; gj < N; gj++) begin : g_bskew
    if (gj == 0) begin : g_direct
      assign b_v_s[0][0]  = in_b[DATA_W-1:0];
      assign bv_v_s[0][0] = inj_v_s;
    end else begin : g_chain
      logic [DATA_W-1:0] d_q [gj];
      logic              v_q [gj];
      // Delay line for B lane gj.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr_s) begin
          for (int k = 0; k < gj; k++) begin
            d_q[k] <= {DATA_W{1'b0}};
            v_q[k] <= 1'b0;
          end
        end else begin
          d_q[0] <= in_b[gj*DATA_W +: DATA_W];
          v_q[0] <= inj_v_s;
          for (int k = 1; k < gj; k++) begin
            d_q[k] <= d_q[k-1];
            v_q[k] <= v_q[k-1];
          end
        end
      end
      assign b_v_s[0][gj]  = d_q[gj-1];
      assign bv_v_s[0][gj] = v_q[gj-1];
    end
  end

  for (gi = 0; gi < M; gi++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr_s),
        .a_i       (a_h_s[gi][gj]),
        .a_valid_i (av_h_s[gi][gj]),
        .b_i       (b_v_s[gi][gj]),
        .b_valid_i (bv_v_s[gi][gj]),
        .a_o       (a_h_s[gi][gj+1]),
        .a_valid_o (av_h_s[gi][gj+1]),
        .b_o       (b_v_s[gi+1][gj]),
        .b_valid_o (bv_v_s[gi+1][gj]),
        .acc_o     (acc_s[gi*N+gj])
      );
    end
  end

  // Tile controller next-state and drain-port next values.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    cnt_d       = cnt_q;
    fl_d        = fl_q;
    idx_d       = idx_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_len_d = k_len;
          cnt_d   = {KW{1'b0}};
          if (k_len == {KW{1'b0}}) begin
            // Accumulators clear on this same edge, so the first word is 0.
            state_d     = DRAIN;
            out_valid_d = 1'b1;
            idx_d       = {IW{1'b0}};
            row_d       = {RW{1'b0}};
            col_d       = {CW{1'b0}};
            out_data_d  = {ACC_W{1'b0}};
          end else begin
            state_d = FEED;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FEED: begin
        if (in_valid) begin
          cnt_d = cnt_q + KW'(1);
          if ((cnt_q + KW'(1)) == k_len_q) begin
            state_d = FLUSH;
            fl_d    = {FW{1'b0}};
          end else begin
            state_d = FEED;
          end
        end else begin
          state_d = FEED;
        end
      end
      FLUSH: begin
        // M+N-1 cycles lets the last beat reach PE(M-1,N-1) and settle.
        if (fl_q == FW'(M+N-2)) begin
          state_d     = DRAIN;
          out_valid_d = 1'b1;
          idx_d       = {IW{1'b0}};
          row_d       = {RW{1'b0}};
          col_d       = {CW{1'b0}};
          out_data_d  = drain_word(acc_s[0]);
        end else begin
          fl_d = fl_q + FW'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == IW'(M*N-1)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            idx_d       = {IW{1'b0}};
            row_d       = {RW{1'b0}};
            col_d       = {CW{1'b0}};
            out_data_d  = {ACC_W{1'b0}};
          end else begin
            idx_d      = idx_nx_s;
            out_data_d = drain_word(acc_s[idx_nx_s]);
            if (col_q == CW'(N-1)) begin
              col_d = {CW{1'b0}};
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Controller and drain-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_len_q     <= {KW{1'b0}};
      cnt_q       <= {KW{1'b0}};
      fl_q        <= {FW{1'b0}};
      idx_q       <= {IW{1'b0}};
      row_q       <= {RW{1'b0}};
      col_q       <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {ACC_W{1'b0}};
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      cnt_q       <= cnt_d;
      fl_q        <= fl_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// tb_systolic_tile_engine: table-driven tiles with hand-computed results,
// plus hand-written sequences for reset and mid-drain reset.
module tb_systolic_tile_engine;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int KW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [KW-1:0]   k_len;
  logic [M*DW-1:0] in_a;
  logic [N*DW-1:0] in_b;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   out_data;
  logic [1:0]      out_row;
  logic [1:0]      out_col;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    int                          k;
    bit                          bubble;
    bit                          stall;
    bit                          ghost;
    logic [7:0][M-1:0][DW-1:0]   a;    // a[beat][lane]
    logic [7:0][N-1:0][DW-1:0]   b;    // b[beat][lane]
    logic [M-1:0][N-1:0][AW-1:0] exp;  // exp[row][col]
  } tile_t;

  tile_t tv [7];

  systolic_tile_engine #(.M(M), .N(N), .DATA_W(DW), .ACC_W(AW), .KW(KW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_len     (k_len),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"},  out_data,           32'd0);
    chk({tag, "_rowcol"},    {28'd0, out_row, out_col}, 32'd0);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_done"},      {31'd0, done},      32'd0);
  endtask

  // Runs one tile from table entry t; stops after stop_at result handshakes.
  task automatic run_tile(input int t, input int stop_at);
    int beat = 0;
    int widx = 0;
    int dones = 0;
    int lat = -1;
    bit held_v = 1'b0;
    logic [AW-1:0] h_data = '0;
    logic [1:0] h_row = '0;
    logic [1:0] h_col = '0;
    @(negedge clk);
    start = 1'b1;
    k_len = tv[t].k[KW-1:0];
    for (int c = 0; c < 400; c++) begin
      if (c > 0) begin
        @(negedge clk);
        start = tv[t].ghost && ((c == 2) || (c == tv[t].k + M + N + 1));
        if (start) k_len = 8'd0;
      end
      in_valid  = (beat < tv[t].k) && (!tv[t].bubble || (c % 2 == 1));
      in_a      = tv[t].a[beat % 8];
      in_b      = tv[t].b[beat % 8];
      out_ready = !tv[t].stall || (c % 4 == 0) || (c % 4 == 3);
      #1;
      if (held_v) begin
        chk($sformatf("t%0d_hold_valid", t), {31'd0, out_valid}, 32'd1);
        chk($sformatf("t%0d_hold_data", t), out_data, h_data);
        chk($sformatf("t%0d_hold_rowcol", t), {28'd0, out_row, out_col}, {28'd0, h_row, h_col});
      end
      if (out_valid && lat < 0) lat = c;
      if (in_valid && in_ready) beat++;
      if (done) dones++;
      held_v = out_valid && !out_ready;
      h_data = out_data;
      h_row  = out_row;
      h_col  = out_col;
      if (out_valid && out_ready) begin
        chk($sformatf("t%0d_w%0d_row", t, widx), {30'd0, out_row}, AW'(widx / N));
        chk($sformatf("t%0d_w%0d_col", t, widx), {30'd0, out_col}, AW'(widx % N));
        chk($sformatf("t%0d_w%0d_data", t, widx), out_data, tv[t].exp[widx / N][widx % N]);
        widx++;
        if (widx == stop_at) break;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk($sformatf("t%0d_words_drained", t), AW'(widx), AW'(stop_at));
    if (stop_at == M * N) begin
      chk($sformatf("t%0d_done_count", t), AW'(dones), 32'd1);
      if (tv[t].k > 0 && !tv[t].bubble) begin
        chk($sformatf("t%0d_latency", t), AW'(lat), AW'(tv[t].k + M + N));
      end
      @(negedge clk);
      #1;
      chk_idle_outputs($sformatf("t%0d_after", t));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    k_len     = '0;
    in_a      = '0;
    in_b      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    for (int t = 0; t < 7; t++) tv[t] = '0;
    // Tile 0: a=2+k, b=3+k for 5 beats -> 6+12+20+30+42 = 110 everywhere.
    tv[0].k = 5;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        tv[0].a[k][i] = DW'(2 + k);
        tv[0].b[k][i] = DW'(3 + k);
      end
    end
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tv[0].exp[i][j] = 32'd110;
    // Tile 1: A identity, B[k][j] = 4k+j+1 -> C[i][j] = 4i+j+1.
    tv[1].k = 4;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        tv[1].a[k][i] = (i == k) ? 8'd1 : 8'd0;
        tv[1].b[k][i] = DW'(4 * k + i + 1);
      end
    end
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tv[1].exp[i][j] = AW'(4 * i + j + 1);
    // Tile 2: tile 1 with input bubbles and output back-pressure.
    tv[2] = tv[1];
    tv[2].bubble = 1'b1;
    tv[2].stall  = 1'b1;
    // Tile 3: -128 * -128 = 16384.
    tv[3].k = 1;
    for (int i = 0; i < 4; i++) begin
      tv[3].a[0][i] = 8'h80;
      tv[3].b[0][i] = 8'h80;
    end
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tv[3].exp[i][j] = 32'd16384;
    // Tile 4: -1 * 1 = -1, clamped to 0 when RELU_EN is defined.
    tv[4].k = 1;
    for (int i = 0; i < 4; i++) begin
      tv[4].a[0][i] = 8'hFF;
      tv[4].b[0][i] = 8'h01;
    end
`ifdef RELU_EN
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tv[4].exp[i][j] = 32'd0;
`else
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tv[4].exp[i][j] = 32'hFFFF_FFFF;
`endif
    // Tile 5: k_len=0 drains 16 zeros, despite nonzero accumulators from tile 4.
    tv[5].k = 0;
    // Tile 6: tile 0 with stray start pulses during FEED and DRAIN.
    tv[6] = tv[0];
    tv[6].ghost = 1'b1;

    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) run_tile(t, M * N);

    // Reset during DRAIN after 5 words, then a clean tile.
    run_tile(0, 5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_tile(0, M * N);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
